// File: rtl/ahbl_ram_march_master.sv
// ---------------------------------------------------------------------------
// ahbl_ram_march_master
//
// AHB-Lite master that runs a March C- self-test over a word-addressed SRAM
// slave. Transfers are single NONSEQ words issued back to back with no IDLE
// cycles between march elements. Every read is checked against the pattern
// that should be stored at that point of the march.
//
// Sequence over N = 2^(AW-2) words, addr = BASE + 4*a:
//   M0  a ascending   : write P
//   M1  a ascending   : read P, then write ~P
//   M2  a descending  : read ~P, then write P
//   M3  a ascending   : read P
//
// Ports
//   HCLK, HRESETn   bus clock, asynchronous active-low reset
//   start           one-cycle launch pulse, honoured only in IDLE or DONE
//   busy            test in progress (M0..DRAIN)
//   done            level, test finished; cleared by the next accepted start
//   pass            done and no mismatching read
//   fail_addr       HADDR of the first mismatching read (0 if none)
//   err_cnt         saturating count of mismatching reads
//   HADDR/HTRANS/HWRITE/HSIZE  address phase outputs
//   HWDATA          write data for the current write data phase
//   HRDATA          read data for the current read data phase
//   HREADY          bus ready
//   state_dbg       current FSM state encoding, for checkers
//
// Handshake: an address phase (HTRANS=NONSEQ) is accepted at a rising edge
// where HREADY=1; it then becomes the data phase, which completes at the next
// rising edge where HREADY=1. While HREADY=0 both the address phase outputs
// and the data phase (HWDATA, pending read check) hold unchanged.
// ---------------------------------------------------------------------------
module ahbl_ram_march_master #(
  parameter int          AW      = 9,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter logic [31:0] PATTERN = 32'hA5A5_5A5A
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_addr,
  output logic [15:0] err_cnt,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic [2:0]  state_dbg
);

  localparam int          IW       = AW - 2;
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M0    = 3'd1,
    ST_M1    = 3'd2,
    ST_M2    = 3'd3,
    ST_M3    = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Address phase state: element, word index and read/write half of M1/M2.
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ph_q, ph_d;       // 0: read half, 1: write half (M1/M2)

  // Data phase register.
  logic          dp_valid_q;
  logic          dp_write_q;
  logic [31:0]   dp_data_q;        // write data or expected read data
  logic [31:0]   dp_addr_q;

  logic          issuing;
  logic          ap_write;
  logic [31:0]   ap_data;
  logic          clear_results;
  logic          read_mismatch;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_ZERO;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and address phase outputs. The state always describes the
  // transfer currently on the address bus, so outputs come straight from it.
  // Element changes are detected on terminal index values, never on wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ph_d          = ph_q;
    clear_results = 1'b0;
    issuing       = 1'b0;
    ap_write      = 1'b0;
    ap_data       = 32'h0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_M0;
          idx_d         = IDX_ZERO;
          ph_d          = 1'b0;
          clear_results = 1'b1;
        end
      end

      ST_M0: begin
        issuing  = 1'b1;
        ap_write = 1'b1;
        ap_data  = PATTERN;
        if (HREADY) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_M1;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_M1: begin
        issuing  = 1'b1;
        ap_write = ph_q;
        ap_data  = ph_q ? ~PATTERN : PATTERN;
        if (HREADY) begin
          ph_d = ~ph_q;
          if (ph_q) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_M2;
              idx_d   = IDX_LAST;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end
      end

      ST_M2: begin
        issuing  = 1'b1;
        ap_write = ph_q;
        ap_data  = ph_q ? PATTERN : ~PATTERN;
        if (HREADY) begin
          ph_d = ~ph_q;
          if (ph_q) begin
            if (idx_q == IDX_ZERO) begin
              state_d = ST_M3;
              idx_d   = IDX_ZERO;
            end else begin
              idx_d = idx_q - IDX_ONE;
            end
          end
        end
      end

      ST_M3: begin
        issuing  = 1'b1;
        ap_data  = PATTERN;
        if (HREADY) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DRAIN;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_DRAIN: begin
        // Wait one full cycle after the last data phase has retired so the
        // final read check is already reflected in err_cnt when done rises.
        if (!dp_valid_q) state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign HTRANS    = issuing ? 2'b10 : 2'b00;
  assign HWRITE    = issuing & ap_write;
  assign HADDR     = issuing ? (BASE + {{(32-AW){1'b0}}, idx_q, 2'b00}) : 32'h0;
  assign HSIZE     = 3'b010;
  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Data phase register: captures the accepted address phase.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_data_q  <= 32'h0;
      dp_addr_q  <= 32'h0;
    end else if (HREADY) begin
      dp_valid_q <= issuing;
      dp_write_q <= HWRITE;
      dp_data_q  <= ap_data;
      dp_addr_q  <= HADDR;
    end
  end

  assign HWDATA = (dp_valid_q && dp_write_q) ? dp_data_q : 32'h0;

  // -------------------------------------------------------------------------
  // Result tracking
  // -------------------------------------------------------------------------
  assign read_mismatch = HREADY && dp_valid_q && !dp_write_q && (HRDATA != dp_data_q);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt   <= 16'h0;
      fail_addr <= 32'h0;
    end else if (clear_results) begin
      err_cnt   <= 16'h0;
      fail_addr <= 32'h0;
    end else if (read_mismatch) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (err_cnt == 16'h0)    fail_addr <= dp_addr_q;
    end
  end

  assign busy = (state_q == ST_M0) || (state_q == ST_M1) || (state_q == ST_M2) ||
                (state_q == ST_M3) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);
  assign pass = done && (err_cnt == 16'h0);

endmodule

// File: tb/tb_ahbl_ram_march_master.sv
// ---------------------------------------------------------------------------
// tb_ahbl_ram_march_master
//
// Drives ahbl_ram_march_master (AW=4, four words) against a behavioural
// pipelined AHB-Lite RAM slave with an optional single stuck-at bit. The
// expected transfer list and the expected error results are built from the
// march rules over a plain array; a negedge monitor checks every accepted
// address phase, every write data word and bus stability across stalls.
// ---------------------------------------------------------------------------
module tb_ahbl_ram_march_master;

  localparam int          AW   = 4;
  localparam int          IW   = AW - 2;
  localparam int          N    = 1 << IW;
  localparam logic [31:0] BASE = 32'h2000_0040;
  localparam logic [31:0] PAT  = 32'hA5A5_5A5A;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        start  = 1'b0;
  logic        HREADY = 1'b1;
  logic        busy, done, pass, HWRITE;
  logic [31:0] fail_addr, HADDR, HWDATA;
  wire  [31:0] HRDATA;
  logic [15:0] err_cnt;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, state_dbg;

  ahbl_ram_march_master #(.AW(AW), .BASE(BASE), .PATTERN(PAT)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_cnt   (err_cnt),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // -------------------------------------------------------------------------
  // Fault model: one bit of one word forced to a fixed value on write.
  // -------------------------------------------------------------------------
  logic fault_en  = 1'b0;
  int   fault_idx = 0;
  int   fault_bit = 0;
  logic fault_val = 1'b0;

  function automatic logic [31:0] apply_fault(input int idx, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (fault_en && idx == fault_idx) r[fault_bit] = fault_val;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural AHB-Lite RAM slave
  // -------------------------------------------------------------------------
  logic [31:0]   mem [N];
  logic          s_dp_valid, s_dp_write;
  logic [IW-1:0] s_dp_idx;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_idx   <= '0;
    end else if (HREADY) begin
      if (s_dp_valid && s_dp_write) mem[s_dp_idx] <= apply_fault(int'(s_dp_idx), HWDATA);
      s_dp_valid <= HTRANS[1];
      s_dp_write <= HWRITE;
      s_dp_idx   <= HADDR[AW-1:2];
    end
  end

  assign HRDATA = (s_dp_valid && !s_dp_write) ? mem[s_dp_idx] : 32'h0;

  // -------------------------------------------------------------------------
  // Reference model / scoreboard queues
  // -------------------------------------------------------------------------
  logic [31:0] exp_addr_q[$];
  logic        exp_wr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] ref_img [N];
  int          ref_err;
  logic [31:0] ref_fail;

  task automatic ref_op(input int a, input logic wr, input logic [31:0] d);
    logic [31:0] addr;
    addr = BASE + 32'(4 * a);
    exp_addr_q.push_back(addr);
    exp_wr_q.push_back(wr);
    exp_data_q.push_back(d);
    if (wr) begin
      ref_img[a] = apply_fault(a, d);
    end else if (ref_img[a] !== d) begin
      ref_err++;
      if (ref_err == 1) ref_fail = addr;
    end
  endtask

  task automatic build_reference();
    exp_addr_q.delete();
    exp_wr_q.delete();
    exp_data_q.delete();
    ref_err  = 0;
    ref_fail = 32'h0;
    for (int a = 0; a < N; a++) ref_op(a, 1'b1, PAT);
    for (int a = 0; a < N; a++) begin ref_op(a, 1'b0, PAT);  ref_op(a, 1'b1, ~PAT); end
    for (int a = N - 1; a >= 0; a--) begin ref_op(a, 1'b0, ~PAT); ref_op(a, 1'b1, PAT); end
    for (int a = 0; a < N; a++) ref_op(a, 1'b0, PAT);
  endtask

  // -------------------------------------------------------------------------
  // Bus monitor (negedge): data phase first, then the address phase that the
  // next rising edge will accept.
  // -------------------------------------------------------------------------
  task automatic monitor();
    logic        m_valid, m_write, prev_stall, p_wr;
    logic [31:0] m_data, p_addr, p_wdata, ea, ed;
    logic [1:0]  p_trans;
    logic        ew;
    m_valid = 1'b0; m_write = 1'b0; m_data = 32'h0; prev_stall = 1'b0;
    p_addr = 32'h0; p_wdata = 32'h0; p_trans = 2'b00; p_wr = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        m_valid    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (HADDR !== p_addr || HTRANS !== p_trans || HWRITE !== p_wr || HWDATA !== p_wdata) begin
            failures++;
            $display("FAIL stall_hold: got addr=%h trans=%b wr=%b wdata=%h, want addr=%h trans=%b wr=%b wdata=%h",
                     HADDR, HTRANS, HWRITE, HWDATA, p_addr, p_trans, p_wr, p_wdata);
          end
        end
        if (m_valid && m_write) begin
          checks++;
          if (HWDATA !== m_data) begin
            failures++;
            $display("FAIL hwdata: got %h want %h", HWDATA, m_data);
          end
        end
        if (HREADY) begin
          m_valid = 1'b0;
          if (HTRANS === 2'b10) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
              failures++;
              $display("FAIL extra_transfer: got addr=%h wr=%b, want no transfer", HADDR, HWRITE);
            end else begin
              ea = exp_addr_q.pop_front();
              ew = exp_wr_q.pop_front();
              ed = exp_data_q.pop_front();
              if (HADDR !== ea || HWRITE !== ew || HSIZE !== 3'b010) begin
                failures++;
                $display("FAIL addr_phase: got addr=%h wr=%b size=%b, want addr=%h wr=%b size=010",
                         HADDR, HWRITE, HSIZE, ea, ew);
              end
              m_valid = 1'b1;
              m_write = ew;
              m_data  = ed;
            end
          end else if (HTRANS !== 2'b00) begin
            checks++;
            failures++;
            $display("FAIL htrans: got %b want 00 or 10", HTRANS);
          end
        end
        prev_stall = !HREADY;
        p_addr = HADDR; p_trans = HTRANS; p_wr = HWRITE; p_wdata = HWDATA;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: one full march run. stall_pct inserts HREADY=0 cycles while an
  // address phase is pending (each adds exactly one cycle); restart_at pulses
  // start mid-run; reset_at asserts HRESETn mid-run and ends the run there.
  // -------------------------------------------------------------------------
  task automatic run_march(input string tag, input int stall_pct,
                           input int restart_at, input int reset_at);
    int stalls    = 0;
    int done_edge = -1;
    build_reference();
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    start  = 1'b1;
    @(posedge HCLK); #1;   // edge 0
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'h0 || fail_addr !== 32'h0) begin
      failures++;
      $display("FAIL %s start_clear: got busy=%b done=%b pass=%b err=%0d fa=%h, want 1 0 0 0 0",
               tag, busy, done, pass, err_cnt, fail_addr);
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == reset_at) begin
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        checks++;
        if (HTRANS !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== 16'h0 ||
            fail_addr !== 32'h0 || HWDATA !== 32'h0 || HADDR !== 32'h0) begin
          failures++;
          $display("FAIL %s mid_reset: got trans=%b busy=%b done=%b err=%0d fa=%h wdata=%h addr=%h, want all 0",
                   tag, HTRANS, busy, done, err_cnt, fail_addr, HWDATA, HADDR);
        end
        HREADY  = 1'b1;
        HRESETn = 1'b1;
        return;
      end
      if (HTRANS === 2'b10 && $urandom_range(99, 0) < stall_pct) begin
        HREADY = 1'b0;
        stalls++;
      end else begin
        HREADY = 1'b1;
      end
      start = (cyc == restart_at);
      @(posedge HCLK); #1;   // edge cyc
      start = 1'b0;
      if (done === 1'b1) begin
        done_edge = cyc;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_level: edge %0d got busy=%b want 1", tag, cyc, busy);
      end
    end
    HREADY = 1'b1;
    checks++;
    if (done_edge != 6 * N + 2 + stalls) begin
      failures++;
      $display("FAIL %s done_edge: got %0d want %0d", tag, done_edge, 6 * N + 2 + stalls);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s transfer_count: got %0d missing want 0", tag, exp_addr_q.size());
    end
    checks++;
    if (err_cnt !== 16'(ref_err) || fail_addr !== ref_fail) begin
      failures++;
      $display("FAIL %s result: got err=%0d fa=%h want err=%0d fa=%h", tag, err_cnt, fail_addr, ref_err, ref_fail);
    end
    checks++;
    if (pass !== (ref_err == 0) || busy !== 1'b0 || HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL %s final_flags: got pass=%b busy=%b trans=%b want pass=%b busy=0 trans=00",
               tag, pass, busy, HTRANS, (ref_err == 0));
    end
  endtask

  task automatic random_fault();
    fault_en  = 1'b1;
    fault_idx = $urandom_range(N - 1, 0);
    fault_bit = $urandom_range(31, 0);
    fault_val = 1'($urandom_range(1, 0));
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_addr !== 32'h0 || err_cnt !== 16'h0 ||
        HADDR !== 32'h0 || HTRANS !== 2'b00 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: got busy=%b done=%b pass=%b fa=%h err=%0d addr=%h trans=%b wr=%b wdata=%h, want all 0",
               busy, done, pass, fail_addr, err_cnt, HADDR, HTRANS, HWRITE, HWDATA);
    end
    checks++;
    if (HSIZE !== 3'b010) begin
      failures++;
      $display("FAIL hsize: got %b want 010", HSIZE);
    end
  endtask

  task automatic test_clean();
    fault_en = 1'b0;
    run_march("clean", 0, 0, 0);
  endtask

  task automatic test_stuck_bit();
    fault_en = 1'b1; fault_idx = 3; fault_bit = 0; fault_val = 1'b1;
    run_march("stuck_w3b0", 0, 0, 0);
  endtask

  task automatic test_rerun_from_done();
    fault_en = 1'b0;
    run_march("rerun", 0, 0, 0);
  endtask

  task automatic test_stalls();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) fault_en = 1'b0;
      else random_fault();
      run_march("stalls", 30, 0, 0);
    end
  endtask

  task automatic test_start_while_busy();
    fault_en = 1'b0;
    run_march("restart_busy", 0, 10, 0);
  endtask

  task automatic test_reset_mid();
    fault_en = 1'b1; fault_idx = 3; fault_bit = 0; fault_val = 1'b1;
    run_march("mid_reset", 0, 0, 15);
    fault_en = 1'b0;
    run_march("after_reset", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      random_fault();
      run_march("b2b_random", $urandom_range(40, 0), 0, 0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean();
    test_stuck_bit();
    test_rerun_from_done();
    test_stalls();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
